// File: rtl/smc777_kb_pkg.sv
// Shared scancode constants, key event type and letter helpers for the SMC-777 keyboard front end.
package smc777_kb_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_F10    = 8'h09;
  localparam logic [7:0] KC_NONE   = 8'h00;

  typedef struct packed {
    logic       make;
    logic       ext;
    logic [7:0] scancode;
  } kb_event_t;

  // Lower-case ASCII of a set-2 letter scancode, KC_NONE for anything else.
  function automatic logic [7:0] kb_letter(input logic [7:0] sc);
    case (sc)
      8'h1C: kb_letter = 8'h61;  8'h32: kb_letter = 8'h62;  8'h21: kb_letter = 8'h63;
      8'h23: kb_letter = 8'h64;  8'h24: kb_letter = 8'h65;  8'h2B: kb_letter = 8'h66;
      8'h34: kb_letter = 8'h67;  8'h33: kb_letter = 8'h68;  8'h43: kb_letter = 8'h69;
      8'h3B: kb_letter = 8'h6A;  8'h42: kb_letter = 8'h6B;  8'h4B: kb_letter = 8'h6C;
      8'h3A: kb_letter = 8'h6D;  8'h31: kb_letter = 8'h6E;  8'h44: kb_letter = 8'h6F;
      8'h4D: kb_letter = 8'h70;  8'h15: kb_letter = 8'h71;  8'h2D: kb_letter = 8'h72;
      8'h1B: kb_letter = 8'h73;  8'h2C: kb_letter = 8'h74;  8'h3C: kb_letter = 8'h75;
      8'h2A: kb_letter = 8'h76;  8'h1D: kb_letter = 8'h77;  8'h22: kb_letter = 8'h78;
      8'h35: kb_letter = 8'h79;  8'h1A: kb_letter = 8'h7A;
      default: kb_letter = KC_NONE;
    endcase
  endfunction

  function automatic logic is_modifier(input logic [7:0] sc);
    is_modifier = (sc == SC_LSHIFT) || (sc == SC_RSHIFT) || (sc == SC_CTRL) ||
                  (sc == SC_CAPS) || (sc == SC_F10);
  endfunction

endpackage

// File: rtl/smc777_keymap.sv
// Combinational key ROM: PS/2 set-2 scancode plus modifiers to an 8-bit SMC-777 key code.
module smc777_keymap
  import smc777_kb_pkg::*;
(
  input  logic [7:0] i_scancode,
  input  logic       i_ext,
  input  logic       i_shift,
  input  logic       i_ctrl,
  output logic [7:0] o_code
);

  logic [7:0] w_letter_ch;
  logic       w_letter;
  logic [7:0] w_lo;
  logic [7:0] w_hi;
  logic [7:0] w_sel;

  assign w_letter_ch = kb_letter(i_scancode);
  assign w_letter    = ~i_ext & (w_letter_ch != KC_NONE);

  // Unshifted / shifted code pair for the pressed key; KC_NONE marks unmapped keys.
  always_comb begin
    w_lo = KC_NONE;
    w_hi = KC_NONE;
    if (i_ext) begin
      case (i_scancode)
        8'h75:   begin w_lo = 8'h1E; w_hi = 8'h1E; end
        8'h72:   begin w_lo = 8'h1F; w_hi = 8'h1F; end
        8'h6B:   begin w_lo = 8'h1D; w_hi = 8'h1D; end
        8'h74:   begin w_lo = 8'h1C; w_hi = 8'h1C; end
        8'h71:   begin w_lo = 8'h7F; w_hi = 8'h7F; end
        8'h5A:   begin w_lo = 8'h0D; w_hi = 8'h0D; end
        8'h4A:   begin w_lo = 8'h2F; w_hi = 8'h2F; end
        default: begin w_lo = KC_NONE; w_hi = KC_NONE; end
      endcase
    end else if (w_letter) begin
      w_lo = w_letter_ch;
      w_hi = w_letter_ch - 8'h20;
    end else begin
      case (i_scancode)
        8'h16:   begin w_lo = 8'h31; w_hi = 8'h21; end
        8'h1E:   begin w_lo = 8'h32; w_hi = 8'h40; end
        8'h26:   begin w_lo = 8'h33; w_hi = 8'h23; end
        8'h25:   begin w_lo = 8'h34; w_hi = 8'h24; end
        8'h2E:   begin w_lo = 8'h35; w_hi = 8'h25; end
        8'h36:   begin w_lo = 8'h36; w_hi = 8'h5E; end
        8'h3D:   begin w_lo = 8'h37; w_hi = 8'h26; end
        8'h3E:   begin w_lo = 8'h38; w_hi = 8'h2A; end
        8'h46:   begin w_lo = 8'h39; w_hi = 8'h28; end
        8'h45:   begin w_lo = 8'h30; w_hi = 8'h29; end
        8'h4E:   begin w_lo = 8'h2D; w_hi = 8'h5F; end
        8'h55:   begin w_lo = 8'h3D; w_hi = 8'h2B; end
        8'h54:   begin w_lo = 8'h5B; w_hi = 8'h7B; end
        8'h5B:   begin w_lo = 8'h5D; w_hi = 8'h7D; end
        8'h4C:   begin w_lo = 8'h3B; w_hi = 8'h3A; end
        8'h52:   begin w_lo = 8'h27; w_hi = 8'h22; end
        8'h0E:   begin w_lo = 8'h60; w_hi = 8'h7E; end
        8'h5D:   begin w_lo = 8'h5C; w_hi = 8'h7C; end
        8'h41:   begin w_lo = 8'h2C; w_hi = 8'h3C; end
        8'h49:   begin w_lo = 8'h2E; w_hi = 8'h3E; end
        8'h4A:   begin w_lo = 8'h2F; w_hi = 8'h3F; end
        8'h29:   begin w_lo = 8'h20; w_hi = 8'h20; end
        8'h5A:   begin w_lo = 8'h0D; w_hi = 8'h0D; end
        8'h66:   begin w_lo = 8'h08; w_hi = 8'h08; end
        8'h76:   begin w_lo = 8'h1B; w_hi = 8'h1B; end
        8'h0D:   begin w_lo = 8'h09; w_hi = 8'h09; end
        default: begin w_lo = KC_NONE; w_hi = KC_NONE; end
      endcase
    end
  end

  // Ctrl folds letters and the @.._ column down to control codes.
  always_comb begin
    w_sel = i_shift ? w_hi : w_lo;
    if (i_ctrl && (w_letter || ((w_sel >= 8'h40) && (w_sel <= 8'h5F)))) begin
      o_code = w_sel & 8'h1F;
    end else begin
      o_code = w_sel;
    end
  end

endmodule

// File: rtl/smc777_kbd_fifo.sv
// SMC-777 keyboard front end: PS/2 event detect, modifier tracking, key translation
// and a small key-code FIFO popped by the core.
module smc777_kbd_fifo
  import smc777_kb_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        kb_rd,
  input  logic        kb_ovf_clr,
  output logic [7:0]  kb_data,
  output logic        kb_valid,
  output logic        kb_ovf,
  output logic        mod_shift,
  output logic        mod_ctrl,
  output logic        caps_lock,
  output logic        break_key
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic               r_old_tgl;
  logic               r_primed;
  logic               r_s1_ev;
  kb_event_t          r_s1_key;
  logic               r_s2_push;
  logic [7:0]         r_s2_code;
  logic               r_shift_l;
  logic               r_shift_r;
  logic               r_ctrl;
  logic               r_caps;
  logic               r_brk;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;

  logic               w_ev;
  logic               w_letter;
  logic               w_shift_eff;
  logic [7:0]         w_code;
  logic               w_push_req;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;

  // The first clock after reset only samples the strobe, so a strobe already high is not an event.
  assign w_ev = r_primed & (ps2_key[10] ^ r_old_tgl);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_old_tgl <= 1'b0;
      r_primed  <= 1'b0;
      r_s1_ev   <= 1'b0;
      r_s1_key  <= '0;
    end else begin
      r_old_tgl <= ps2_key[10];
      r_primed  <= 1'b1;
      r_s1_ev   <= w_ev;
      r_s1_key  <= ps2_key[9:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
      r_ctrl    <= 1'b0;
      r_caps    <= 1'b0;
      r_brk     <= 1'b0;
    end else if (r_s1_ev) begin
      case (r_s1_key.scancode)
        SC_LSHIFT: r_shift_l <= r_s1_key.make;
        SC_RSHIFT: r_shift_r <= r_s1_key.make;
        SC_CTRL:   r_ctrl    <= r_s1_key.make;
        SC_CAPS:   r_caps    <= r_caps ^ r_s1_key.make;
        SC_F10:    r_brk     <= r_s1_key.make;
        default:   r_brk     <= r_brk;
      endcase
    end
  end

  // Lookup sees modifier state from before this event; modifiers update at the same edge.
  assign w_letter    = ~r_s1_key.ext & (kb_letter(r_s1_key.scancode) != KC_NONE);
  assign w_shift_eff = mod_shift ^ (r_caps & w_letter);
  assign w_push_req  = r_s1_ev & r_s1_key.make & ~is_modifier(r_s1_key.scancode) &
                       (w_code != KC_NONE);

  smc777_keymap u_keymap (
    .i_scancode (r_s1_key.scancode),
    .i_ext      (r_s1_key.ext),
    .i_shift    (w_shift_eff),
    .i_ctrl     (r_ctrl),
    .o_code     (w_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_push <= 1'b0;
      r_s2_code <= KC_NONE;
    end else begin
      r_s2_push <= w_push_req;
      r_s2_code <= w_code;
    end
  end

  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = kb_rd & (r_count != '0);
  assign w_wr   = r_s2_push & (~w_full | w_pop);
  assign w_drop = r_s2_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_s2_code;
        r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (kb_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign kb_data   = r_mem[r_rd_ptr];
  assign kb_valid  = (r_count != '0);
  assign kb_ovf    = r_ovf;
  assign mod_shift = r_shift_l | r_shift_r;
  assign mod_ctrl  = r_ctrl;
  assign caps_lock = r_caps;
  assign break_key = r_brk;

endmodule

// File: tb/tb_smc777_kbd_fifo.sv
// Self-checking bench for smc777_kbd_fifo: directed scenarios plus random key traffic
// compared against a table-driven keyboard model.
module tb_smc777_kbd_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        kb_rd;
  logic        kb_ovf_clr;
  logic [7:0]  kb_data;
  logic        kb_valid;
  logic        kb_ovf;
  logic        mod_shift;
  logic        mod_ctrl;
  logic        caps_lock;
  logic        break_key;

  smc777_kbd_fifo #(.FIFO_AW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .kb_rd      (kb_rd),
    .kb_ovf_clr (kb_ovf_clr),
    .kb_data    (kb_data),
    .kb_valid   (kb_valid),
    .kb_ovf     (kb_ovf),
    .mod_shift  (mod_shift),
    .mod_ctrl   (mod_ctrl),
    .caps_lock  (caps_lock),
    .break_key  (break_key)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference keyboard: a key table plus modifier state and an 8-deep code queue.
  typedef struct {
    logic       ext;
    logic [7:0] sc;
    logic [7:0] lo;
    logic [7:0] hi;
    bit         letter;
  } key_t;

  key_t       keys[$];
  logic [7:0] m_q[$];
  bit         m_shl, m_shr, m_ctrl, m_caps, m_brk, m_ovf;

  logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] oth_sc [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                             8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h0E, 8'h5D, 8'h41, 8'h49, 8'h4A};
  logic [7:0] oth_lo [21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30,
                             8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h3B, 8'h27, 8'h60, 8'h5C, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] oth_hi [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29,
                             8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h3A, 8'h22, 8'h7E, 8'h7C, 8'h3C, 8'h3E, 8'h3F};
  logic [7:0] fix_sc [12] = '{8'h29, 8'h5A, 8'h66, 8'h76, 8'h0D, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h71, 8'h5A, 8'h4A};
  logic [7:0] fix_cd [12] = '{8'h20, 8'h0D, 8'h08, 8'h1B, 8'h09, 8'h1E, 8'h1F, 8'h1D, 8'h1C, 8'h7F, 8'h0D, 8'h2F};
  logic [7:0] nomap_sc [4] = '{8'h05, 8'h06, 8'h04, 8'h0C};

  function automatic void add_key(logic ext, logic [7:0] sc, logic [7:0] lo, logic [7:0] hi, bit letter);
    key_t k;
    k.ext = ext; k.sc = sc; k.lo = lo; k.hi = hi; k.letter = letter;
    keys.push_back(k);
  endfunction

  function automatic void build_table();
    for (int i = 0; i < 26; i++) add_key(1'b0, let_sc[i], 8'h61 + 8'(i), 8'h41 + 8'(i), 1'b1);
    for (int i = 0; i < 21; i++) add_key(1'b0, oth_sc[i], oth_lo[i], oth_hi[i], 1'b0);
    for (int i = 0; i < 12; i++) add_key(i >= 5, fix_sc[i], fix_cd[i], fix_cd[i], 1'b0);
  endfunction

  function automatic logic [7:0] model_code(logic ext, logic [7:0] sc);
    logic [7:0] ch;
    bit         up;
    ch = 8'h00;
    foreach (keys[i]) begin
      if (keys[i].ext == ext && keys[i].sc == sc) begin
        up = m_shl || m_shr;
        if (keys[i].letter) up = up ^ m_caps;
        ch = up ? keys[i].hi : keys[i].lo;
        if (m_ctrl && keys[i].letter) ch = keys[i].hi - 8'h40;
        else if (m_ctrl && ch >= 8'h40 && ch <= 8'h5F) ch = ch - 8'h40;
      end
    end
    return ch;
  endfunction

  function automatic void model_event(logic make, logic ext, logic [7:0] sc);
    logic [7:0] c;
    case (sc)
      8'h12: m_shl = make;
      8'h59: m_shr = make;
      8'h14: m_ctrl = make;
      8'h58: if (make) m_caps = !m_caps;
      8'h09: m_brk = make;
      default: begin
        if (make) begin
          c = model_code(ext, sc);
          if (c != 8'h00) begin
            if (m_q.size() < 8) m_q.push_back(c);
            else m_ovf = 1'b1;
          end
        end
      end
    endcase
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_shl = 0; m_shr = 0; m_ctrl = 0; m_caps = 0; m_brk = 0; m_ovf = 0;
  endfunction

  task automatic drive_ev(input logic make, input logic ext, input logic [7:0] sc);
    ps2_key = {~ps2_key[10], make, ext, sc};
    model_event(make, ext, sc);
  endtask

  task automatic key(input logic make, input logic ext, input logic [7:0] sc);
    @(negedge clk);
    drive_ev(make, ext, sc);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    kb_rd = 1'b1;
    @(negedge clk);
    kb_rd = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic clr_ovf();
    @(negedge clk);
    kb_ovf_clr = 1'b1;
    @(negedge clk);
    kb_ovf_clr = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".valid"}, kb_valid, m_q.size() > 0);
    if (m_q.size() > 0) check_eq({tag, ".data"}, kb_data, m_q[0]);
    check_eq({tag, ".ovf"}, kb_ovf, m_ovf);
    check_eq({tag, ".shift"}, mod_shift, m_shl || m_shr);
    check_eq({tag, ".ctrl"}, mod_ctrl, m_ctrl);
    check_eq({tag, ".caps"}, caps_lock, m_caps);
    check_eq({tag, ".brk"}, break_key, m_brk);
  endtask

  task automatic do_reset(input logic strobe);
    reset = 1'b1;
    ps2_key = {strobe, 10'h000};
    kb_rd = 1'b0;
    kb_ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("rst");
    reset = 1'b0;
  endtask

  initial begin
    int seen;
    int popped;
    int r;
    int idx;
    build_table();

    // Strobe already high at reset release must not produce a key.
    do_reset(1'b1);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kb_valid) seen++;
    end
    check_eq("no_spurious", seen, 0);

    // Three-clock latency for a plain 'a'.
    @(negedge clk);
    drive_ev(1'b1, 1'b0, 8'h1C);
    @(negedge clk); check_eq("lat1.valid", kb_valid, 1'b0);
    @(negedge clk); check_eq("lat2.valid", kb_valid, 1'b0);
    @(negedge clk); check_eq("lat3.valid", kb_valid, 1'b1);
    check_eq("lat3.data", kb_data, 8'h61);
    kb_rd = 1'b1;
    @(negedge clk);
    kb_rd = 1'b0;
    void'(m_q.pop_front());
    check_eq("pop.valid", kb_valid, 1'b0);

    // Shift and Caps Lock.
    key(1, 0, 8'h12); key(1, 0, 8'h1C); key(0, 0, 8'h12); key(1, 0, 8'h1C);
    check_eq("shiftA", kb_data, 8'h41); pop_one();
    check_eq("plainA", kb_data, 8'h61); pop_one();
    key(1, 0, 8'h58); key(0, 0, 8'h58); key(1, 0, 8'h1C);
    check_eq("capsA", kb_data, 8'h41); pop_one();
    key(1, 0, 8'h12); key(1, 0, 8'h16);
    check_eq("caps_shift1", kb_data, 8'h21); pop_one();
    key(1, 0, 8'h1C);
    check_eq("caps_shiftA", kb_data, 8'h61); pop_one();
    key(0, 0, 8'h12); key(1, 0, 8'h58);
    check_state("caps_off");

    // Back-to-back strobes on consecutive clocks.
    @(negedge clk); drive_ev(1, 0, 8'h12);
    @(negedge clk); drive_ev(1, 0, 8'h1C);
    @(negedge clk); drive_ev(0, 0, 8'h12);
    @(negedge clk); drive_ev(1, 0, 8'h32);
    repeat (4) @(negedge clk);
    check_eq("b2b.first", kb_data, 8'h41); pop_one();
    check_eq("b2b.second", kb_data, 8'h62); pop_one();
    check_state("b2b");

    // Ctrl, ignored breaks, F10.
    key(1, 0, 8'h14); key(1, 0, 8'h21);
    check_eq("ctrlC", kb_data, 8'h03); pop_one();
    key(0, 0, 8'h14);
    key(0, 0, 8'h1C);
    check_eq("break_only.valid", kb_valid, 1'b0);
    key(1, 0, 8'h09);
    check_eq("f10_make", break_key, 1'b1);
    check_eq("f10_make.valid", kb_valid, 1'b0);
    key(0, 0, 8'h09);
    check_eq("f10_break", break_key, 1'b0);

    // Overflow on the ninth key; the first eight pop in order.
    for (int i = 0; i < 9; i++) key(1, 0, let_sc[i]);
    check_eq("ovf_set", kb_ovf, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_eq("ovf_order", kb_data, 8'h61 + 8'(i));
      pop_one();
    end
    check_eq("ovf_drain.valid", kb_valid, 1'b0);
    clr_ovf();
    check_eq("ovf_clr", kb_ovf, 1'b0);

    // Push and pop at the same edge while full.
    for (int i = 0; i < 8; i++) key(1, 0, let_sc[i]);
    void'(m_q.pop_front());
    @(negedge clk); drive_ev(1, 0, let_sc[9]);
    @(negedge clk);
    @(negedge clk); kb_rd = 1'b1;
    @(negedge clk); kb_rd = 1'b0;
    check_eq("full_pushpop.ovf", kb_ovf, 1'b0);
    popped = 0;
    for (int i = 0; i < 12 && kb_valid; i++) begin
      check_eq("full_pushpop.data", kb_data, m_q[0]);
      pop_one();
      popped++;
    end
    check_eq("full_pushpop.count", popped, 8);

    // Asynchronous reset mid-stream.
    key(1, 0, 8'h12);
    for (int i = 0; i < 4; i++) key(1, 0, let_sc[i]);
    check_eq("pre_rst.valid", kb_valid, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst.valid", kb_valid, 1'b0);
    check_eq("async_rst.shift", mod_shift, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    key(1, 0, 8'h1C);
    check_eq("post_rst.data", kb_data, 8'h61);
    check_state("post_rst");

    // Random key traffic against the model.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        idx = $urandom_range(0, keys.size() - 1);
        key(1, keys[idx].ext, keys[idx].sc);
      end else if (r < 48) begin
        idx = $urandom_range(0, keys.size() - 1);
        key(0, keys[idx].ext, keys[idx].sc);
      end else if (r < 56) begin
        key($urandom_range(0, 1), 0, ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59);
      end else if (r < 61) begin
        key($urandom_range(0, 1), $urandom_range(0, 1), 8'h14);
      end else if (r < 64) begin
        key(1, 0, 8'h58);
      end else if (r < 67) begin
        key($urandom_range(0, 1), 0, 8'h09);
      end else if (r < 70) begin
        key(1, 0, nomap_sc[$urandom_range(0, 3)]);
      end else if (r < 96) begin
        pop_one();
      end else begin
        clr_ovf();
      end
      check_state("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
